// File: rtl/controle_venda.sv
// controle_venda: vending-machine transaction FSM; key capture, product lookup,
// coin accumulation and timed release/refund, paced by a 1 Hz tick.
module controle_venda #(
  parameter int T_DIG   = 15,
  parameter int T_MOEDA = 15,
  parameter int T_SAIDA = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       tecla_valida,
  input  logic [1:0] tecla_cod,
  input  logic       moeda_valida,
  input  logic [1:0] moeda,
  input  logic       cancela,
  input  logic       existe,
  input  logic [2:0] preco,
  output logic [1:0] linha,
  output logic [1:0] coluna,
  output logic       consulta,
  output logic [3:0] acumulado,
  output logic [3:0] troco,
  output logic       LP,
  output logic       DM,
  output logic [2:0] estado
);
  localparam int TMAX = (T_DIG > T_MOEDA) ? ((T_DIG > T_SAIDA) ? T_DIG : T_SAIDA)
                                          : ((T_MOEDA > T_SAIDA) ? T_MOEDA : T_SAIDA);
  localparam int CW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {
    OCIOSO = 3'd0, ESPERA_COL = 3'd1, CONSULTA = 3'd2,
    MOEDAS = 3'd3, LIBERA = 3'd4, DEVOLVE = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [1:0] linha_q, linha_d, coluna_q, coluna_d;
  logic [2:0] preco_q, preco_d;
  logic [3:0] acum_q, acum_d, troco_q, troco_d, soma_sat;
  logic [4:0] soma;
  logic lp_q, dm_q, consulta_q, coin, timeout, restart;
  assign lim = state_q == ESPERA_COL ? CW'(T_DIG) : state_q == MOEDAS ? CW'(T_MOEDA) : CW'(T_SAIDA);
  assign timeout = tick && cnt_q == lim - CW'(1);
  assign coin = moeda_valida && moeda != 2'd0;
  assign soma = {1'b0, acum_q} + {3'b0, moeda};
  assign soma_sat = soma[4] ? 4'hF : soma[3:0];
  always_comb begin
    state_d  = state_q;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    preco_d  = preco_q;
    acum_d   = acum_q;
    troco_d  = troco_q;
    restart  = 1'b0;
    case (state_q)
      OCIOSO: begin
        acum_d = 4'd0;
        if (tecla_valida) begin
          linha_d = tecla_cod;
          state_d = ESPERA_COL;
        end
      end
      ESPERA_COL:
        if (cancela || timeout) begin
          state_d  = OCIOSO;
          linha_d  = 2'd0;
          coluna_d = 2'd0;
        end else if (tecla_valida) begin
          coluna_d = tecla_cod;
          state_d  = CONSULTA;
        end
      CONSULTA:
        if (existe) begin
          preco_d = preco;
          state_d = MOEDAS;
        end else begin
          state_d  = OCIOSO;
          linha_d  = 2'd0;
          coluna_d = 2'd0;
        end
      MOEDAS:
        if (acum_q >= {1'b0, preco_q}) begin
          state_d = LIBERA;
          troco_d = acum_q - {1'b0, preco_q};
        end else if (coin) begin
          // coin is counted before any cancel in the same cycle
          acum_d  = soma_sat;
          restart = 1'b1;
          if (cancela) begin
            state_d = DEVOLVE;
            troco_d = soma_sat;
          end
        end else if (cancela || timeout) begin
          state_d  = acum_q != 4'd0 ? DEVOLVE : OCIOSO;
          troco_d  = acum_q;
          linha_d  = acum_q != 4'd0 ? linha_q : 2'd0;
          coluna_d = acum_q != 4'd0 ? coluna_q : 2'd0;
        end
      LIBERA, DEVOLVE:
        if (timeout) begin
          state_d  = OCIOSO;
          acum_d   = 4'd0;
          troco_d  = 4'd0;
          linha_d  = 2'd0;
          coluna_d = 2'd0;
        end
      default: begin
        state_d  = OCIOSO;
        acum_d   = 4'd0;
        troco_d  = 4'd0;
        linha_d  = 2'd0;
        coluna_d = 2'd0;
      end
    endcase
    cnt_d = (state_d != state_q || restart) ? '0 :
            (tick && cnt_q != CW'(TMAX)) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= OCIOSO;
      cnt_q      <= '0;
      linha_q    <= 2'd0;
      coluna_q   <= 2'd0;
      preco_q    <= 3'd0;
      acum_q     <= 4'd0;
      troco_q    <= 4'd0;
      lp_q       <= 1'b0;
      dm_q       <= 1'b0;
      consulta_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      linha_q    <= linha_d;
      coluna_q   <= coluna_d;
      preco_q    <= preco_d;
      acum_q     <= acum_d;
      troco_q    <= troco_d;
      lp_q       <= state_d == LIBERA;
      dm_q       <= state_d == DEVOLVE;
      consulta_q <= state_d == CONSULTA;
    end
  assign linha     = linha_q;
  assign coluna    = coluna_q;
  assign consulta  = consulta_q;
  assign acumulado = acum_q;
  assign troco     = troco_q;
  assign LP        = lp_q;
  assign DM        = dm_q;
  assign estado    = state_q;
endmodule

// File: doc/controle_venda.md
# controle_venda

Transaction sequencer for the vending machine datapath. It captures the two-key product code (row, column) and sequences the product-table lookup. It then accumulates inserted coins against the latched price, and drives a timed dispense or refund phase before returning to idle. It replaces the loose glue between keypad decoder, selector, accumulator, comparator and end-of-sale timers with a single registered FSM clocked by the system clock and paced by a 1 Hz enable tick.

## Interface
- T_DIG, default 15: tick count allowed between row key and column key.
- T_MOEDA, default 15: tick count of coin inactivity before refund.
- T_SAIDA, default 5: tick count that LP or DM is held.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; forces all registers to reset values.
- tick  input  1  one-clk-wide 1 Hz enable pulse, synchronous to clk.
- tecla_valida  input  1  one-clk pulse; a key code is present on tecla_cod.
- tecla_cod  input  2  key code 0..3.
- moeda_valida  input  1  one-clk pulse; a coin is present on moeda.
- moeda  input  2  coin value 1..3; value 0 with moeda_valida is ignored.
- cancela  input  1  one-clk pulse; user abort.
- existe  input  1  selector: product at (linha, coluna) exists; valid combinationally while consulta=1.
- preco  input  3  selector: price of addressed product, valid with existe.
- linha, coluna  output  2 each  latched key codes, drive selector address.
- consulta  output  1  high during the lookup cycle (selector enable).
- acumulado  output  4  coin sum, saturating.
- troco  output  4  change amount; valid while LP or DM is high.
- LP  output  1  release product.
- DM  output  1  return coins.
- estado  output  3  current FSM state code for display.

## Operation
- States and codes: OCIOSO=0, ESPERA_COL=1, CONSULTA=2, MOEDAS=3, LIBERA=4, DEVOLVE=5. Codes 6–7 are unreachable and recover to OCIOSO next cycle.
- Tick counter: clears on every state entry. It increments on tick. A timeout fires on the tick that brings it to the state's limit, so the limit is T ticks after entry.
- OCIOSO: on tecla_valida, latch linha=tecla_cod and go to ESPERA_COL. Coins and cancela are ignored. acumulado=0.
- ESPERA_COL:
  - tecla_valida: latch coluna=tecla_cod and go to CONSULTA.
  - T_DIG timeout or cancela: go to OCIOSO and clear linha/coluna.
- CONSULTA: lasts exactly one cycle with consulta=1.
  - existe=1: latch preco into an internal register and go to MOEDAS.
  - existe=0: go to OCIOSO and clear linha/coluna.
- MOEDAS:
  - Valid coin (moeda≠0) adds to acumulado, saturating at 15, and restarts the tick counter.
  - Whenever acumulado ≥ latched preco (checked on the registered value), go to LIBERA with troco=acumulado−preco.
  - T_MOEDA timeout or cancela: if acumulado>0, go to DEVOLVE with troco=acumulado; else go to OCIOSO.
  - Keys are ignored.
- LIBERA: LP=1 for T_SAIDA ticks, then go to OCIOSO and clear acumulado, troco, linha, coluna. All inputs except reset are ignored.
- DEVOLVE: same as LIBERA, with DM=1 instead of LP.
- Price 0 is legal: MOEDAS then LIBERA on the following cycle with troco=0.
- All outputs are registered. LP and DM are never high together.

## Timing
- Reset values: estado=0, linha=0, coluna=0, consulta=0, acumulado=0, troco=0, LP=0, DM=0, tick counter=0.
- Reset asserted mid-transaction aborts it: no LP or DM pulse and coins are lost. Deassertion is assumed synchronised externally.
- Key to state change: tecla_valida at edge n gives estado and latch updated at edge n+1.
- Lookup: CONSULTA at cycle c gives MOEDAS or OCIOSO at c+1.
- Coin to release: coin sampled at edge n makes acumulado valid after n. The ≥ test at edge n+1 gives LP=1 after n+1, a 2-cycle latency.
- Simultaneous events:
  - Coin and timeout tick in the same cycle: the coin wins and the counter restarts.
  - cancela and coin in the same cycle: the coin is added first, then DEVOLVE with the new sum.
  - cancela and column key in the same cycle: cancel wins.
- Counter width: ceil(log2(max(T)+1)) bits, with no wrap before the limit.

## Test plan
- Happy path: keys 2 then 1, existe=1, preco=5, coins 2,3 → LP high for 5 ticks, troco=0, then estado=0 and acumulado=0.
- Overpay: preco=3, coins 2,2 → LIBERA with troco=1; LP width exactly T_SAIDA ticks.
- Missing product: keys 3,3 with existe=0 → CONSULTA for one cycle, then OCIOSO; no LP, no DM.
- Digit timeout: row key, then 15 ticks with no key → OCIOSO and linha=0; a coin during this phase leaves acumulado=0.
- Coin timeout and cancel:
  - preco=7, coin 3, 15 idle ticks → DM for 5 ticks with troco=3.
  - Repeat with cancela → DM immediately with troco=3.
  - cancela with acumulado=0 → OCIOSO with no DM.
- Saturation and reset:
  - preco=7 with forced preco path, six coins of 3 injected while the compare is masked → acumulado stops at 15.
  - reset low during LIBERA → LP=0 and estado=0 immediately.
